dsi_lanes_receiver: RTL and testbench
=====================================

Name: dsi_lanes_receiver

Overview:
HS-mode receive-side lane merger for the DSI link. It takes per-lane deserialized bytes from 1–4 data lanes and checks the per-lane 0xB8 sync byte. It de-interleaves payload bytes in lane round-robin order and repacks them into 32-bit words with byte strobes and a last-word flag. It mirrors the word interface on the transmit side of dsi_lanes_controller and serves as the loopback checker and receive front end.

Parameters:
SYNC_BYTE, 8'hB8, HS leader byte required on every active lane at burst start
CNT_W, 16, width of payload byte counter

Ports:
clk_sys  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
reg_lanes_number  in  2  active lanes minus 1 (0 = 1 lane … 3 = 4 lanes), sampled at burst start
lane_data  in  32  byte of lane i on bits [8i+7:8i]
lane_valid  in  4  byte valid per lane (HS byte present this cycle)
iface_read_data  out  32  payload word, byte 0 in [7:0]
iface_read_strb  out  4  valid bytes of word, always LSB-contiguous
iface_read_valid  out  1  word strobe, single cycle, no backpressure
iface_read_last  out  1  final word of burst, qualified by iface_read_valid
rx_active  out  1  high from sync accept until burst flush complete
byte_count  out  CNT_W  payload bytes of last completed burst, saturating
sync_error  out  1  one-cycle pulse
lane_error  out  1  one-cycle pulse

Behaviour:
- Reset: every output is 0. State is IDLE, and the accumulator, held word and counters are cleared. A reset mid-burst discards all partial data and emits nothing.
- Active mask M = low (reg_lanes_number+1) bits. It is latched on the IDLE→DATA transition. lane_valid bits outside M are ignored.
- IDLE:
  - Waits for any lane_valid & M ≠ 0.
  - Sync accepted when (lane_valid & M) == M and every active lane byte == SYNC_BYTE. Then go to DATA and set rx_active=1 on the next cycle.
  - Otherwise: pulse sync_error and go to DROP.
- DATA: per cycle, v = lane_valid & M. v must be a prefix pattern (0, 0001, 0011, 0111, 1111 within M).
  - v == M: append N bytes, lane 0 first.
  - v a non-zero proper prefix: append k bytes and set the partial flag. The next cycle must have v == 0; any other value is a lane error.
  - v == 0: go to FLUSH.
  - Non-prefix v, or a non-zero v after a partial cycle: pulse lane_error, discard the held word and accumulator, deassert rx_active, go to DROP.
- Packing:
  - The accumulator holds 0–3 leftover bytes plus up to 4 new bytes.
  - Whenever ≥4 bytes are present, the oldest 4 form a complete word.
  - A complete word is held one step. It is presented (iface_read_valid=1, strb=4'hF, last=0) the cycle after the next byte-bearing DATA cycle, or during FLUSH.
  - At most one word is output per cycle. A held word plus a new complete word in the same cycle is legal: the held word goes out and the new one becomes held.
- FLUSH, 1–2 cycles:
  - Held word present and partial bytes remain: emit the held word (last=0), then the partial word with strb = (1<<r)-1, zero-filled upper bytes, last=1.
  - Only a held word: emit it with last=1.
  - Only partial bytes: emit them with last=1.
  - Zero payload bytes: no word output.
  - After flush: update byte_count, clear rx_active, return to IDLE.
  - lane_valid is ignored during FLUSH.
- DROP: wait until lane_valid & 4'hF == 0, then go to IDLE. No word output.
- byte_count: the internal counter increments by bytes appended and saturates at 2^CNT_W−1. It is copied to byte_count at FLUSH end and left unchanged on error.
- Simultaneous sync_error/lane_error cannot occur; each is tied to its state.

Test Plan:
- 4 lanes, 8 bytes:
  - Stimulus: cycle0 all B8, cycle1 bytes 01..04, cycle2 bytes 05..08, cycle3 valid=0.
  - Response: 0x04030201 strb F last0, then 0x08070605 strb F last1; byte_count=8.
- 2 lanes, 5 bytes:
  - Stimulus: B8/B8, (AA,BB), (CC,DD), lane0-only EE, then 0.
  - Response: 0xDDCCBBAA strb F last0, then 0x000000EE strb 1 last1; byte_count=5.
- 1 lane, 3 bytes:
  - Stimulus: B8, 11, 22, 33, 0.
  - Response: single word 0x00332211 strb 7 last1.
- Sync error:
  - Stimulus: 4 lanes, lane2 sends B9 at start.
  - Response: sync_error pulse, no words, rx_active stays 0, next valid burst received normally.
- Lane error:
  - Stimulus: 4 lanes, after sync a cycle with valid=0101.
  - Response: lane_error pulse, no word with last, byte_count unchanged.
- Reset mid-burst:
  - Stimulus: assert rst after 6 payload bytes.
  - Response: all outputs 0 the next cycle, no words emitted, a fresh burst decodes correctly.

Source files
------------

// File: rtl/dsi_lanes_receiver.sv
// dsi_lanes_receiver
// HS-mode receive lane merger. Checks the leader byte on every active lane at
// burst start, de-interleaves payload bytes in lane order (lane 0 first) and
// repacks them into 32-bit words with LSB-contiguous byte strobes and a
// last-word flag.
//
// Ports:
//   clk_sys            system clock, rising edge
//   rst                synchronous reset, active-high
//   reg_lanes_number   active lanes minus 1, sampled at burst start
//   lane_data          byte of lane i on [8i+7:8i]
//   lane_valid         per-lane HS byte present
//   iface_read_*       word output (data/strb/valid/last), no backpressure
//   rx_active          high from sync accept until flush completes
//   byte_count         payload bytes of last completed burst (saturating)
//   sync_error         one-cycle pulse on bad leader
//   lane_error         one-cycle pulse on illegal lane-valid pattern
//
// state   | meaning
// S_IDLE  | waiting for leader bytes on the active lanes
// S_DATA  | accepting payload bytes, packing into words
// S_FLUSH | emitting held word and/or trailing partial word
// S_DROP  | discarding until every lane goes quiet
module dsi_lanes_receiver #(
  parameter logic [7:0] SYNC_BYTE = 8'hB8,
  parameter int         CNT_W     = 16
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic [1:0]       reg_lanes_number,
  input  logic [31:0]      lane_data,
  input  logic [3:0]       lane_valid,
  output logic [31:0]      iface_read_data,
  output logic [3:0]       iface_read_strb,
  output logic             iface_read_valid,
  output logic             iface_read_last,
  output logic             rx_active,
  output logic [CNT_W-1:0] byte_count,
  output logic             sync_error,
  output logic             lane_error
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_FLUSH, S_DROP} state_t;

  state_t           r_state;
  logic [3:0]       r_mask;
  logic             r_partial;
  logic [23:0]      r_acc;
  logic [1:0]       r_acc_cnt;
  logic [31:0]      r_held;
  logic             r_held_vld;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0]       w_mask_cfg;
  logic [3:0]       w_v_idle;
  logic             w_sync_ok;
  logic [3:0]       w_v;
  logic [2:0]       w_k;
  logic             w_prefix;
  logic [31:0]      w_new;
  logic [55:0]      w_comb;
  logic [2:0]       w_total;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_cnt_next;
  logic [3:0]       w_part_strb;

  always_comb begin
    w_mask_cfg = 4'b0001;
    case (reg_lanes_number)
      2'd0: w_mask_cfg = 4'b0001;
      2'd1: w_mask_cfg = 4'b0011;
      2'd2: w_mask_cfg = 4'b0111;
      2'd3: w_mask_cfg = 4'b1111;
      default: w_mask_cfg = 4'b0001;
    endcase
  end

  assign w_v_idle = lane_valid & w_mask_cfg;

  always_comb begin
    w_sync_ok = (w_v_idle == w_mask_cfg);
    for (int i = 0; i < 4; i++) begin
      if (w_mask_cfg[i] && (lane_data[8*i +: 8] != SYNC_BYTE)) w_sync_ok = 1'b0;
    end
  end

  assign w_v = lane_valid & r_mask;

  // Only lane-0-first prefixes are legal; the count doubles as the append size.
  always_comb begin
    w_prefix = 1'b1;
    w_k      = 3'd0;
    case (w_v)
      4'b0000: w_k = 3'd0;
      4'b0001: w_k = 3'd1;
      4'b0011: w_k = 3'd2;
      4'b0111: w_k = 3'd3;
      4'b1111: w_k = 3'd4;
      default: w_prefix = 1'b0;
    endcase
  end

  // Invalid lanes are zeroed so leftover bytes above r_acc_cnt stay zero,
  // which gives the zero-filled upper bytes of a partial word for free.
  always_comb begin
    w_new = '0;
    for (int i = 0; i < 4; i++) w_new[8*i +: 8] = lane_data[8*i +: 8] & {8{w_v[i]}};
  end

  assign w_comb  = {32'b0, r_acc} | ({24'b0, w_new} << {r_acc_cnt, 3'b000});
  assign w_total = {1'b0, r_acc_cnt} + w_k;

  assign w_sum      = {1'b0, r_cnt} + (CNT_W+1)'(w_k);
  assign w_cnt_next = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

  always_comb begin
    w_part_strb = 4'b0000;
    case (r_acc_cnt)
      2'd1: w_part_strb = 4'b0001;
      2'd2: w_part_strb = 4'b0011;
      2'd3: w_part_strb = 4'b0111;
      default: w_part_strb = 4'b0000;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_mask           <= 4'b0;
      r_partial        <= 1'b0;
      r_acc            <= '0;
      r_acc_cnt        <= '0;
      r_held           <= '0;
      r_held_vld       <= 1'b0;
      r_cnt            <= '0;
      iface_read_data  <= '0;
      iface_read_strb  <= '0;
      iface_read_valid <= 1'b0;
      iface_read_last  <= 1'b0;
      rx_active        <= 1'b0;
      byte_count       <= '0;
      sync_error       <= 1'b0;
      lane_error       <= 1'b0;
    end else begin
      iface_read_data  <= '0;
      iface_read_strb  <= '0;
      iface_read_valid <= 1'b0;
      iface_read_last  <= 1'b0;
      sync_error       <= 1'b0;
      lane_error       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_v_idle != 4'b0) begin
            if (w_sync_ok) begin
              r_state    <= S_DATA;
              r_mask     <= w_mask_cfg;
              rx_active  <= 1'b1;
              r_partial  <= 1'b0;
              r_acc      <= '0;
              r_acc_cnt  <= '0;
              r_held_vld <= 1'b0;
              r_cnt      <= '0;
            end else begin
              sync_error <= 1'b1;
              r_state    <= S_DROP;
            end
          end
        end
        S_DATA: begin
          if (!w_prefix || (r_partial && (w_v != 4'b0))) begin
            lane_error <= 1'b1;
            rx_active  <= 1'b0;
            r_held_vld <= 1'b0;
            r_acc      <= '0;
            r_acc_cnt  <= '0;
            r_partial  <= 1'b0;
            r_state    <= S_DROP;
          end else if (w_v == 4'b0) begin
            r_state <= S_FLUSH;
          end else begin
            // Any byte-bearing cycle releases the word held from before.
            if (r_held_vld) begin
              iface_read_data  <= r_held;
              iface_read_strb  <= 4'hF;
              iface_read_valid <= 1'b1;
            end
            if (w_total[2]) begin
              r_held     <= w_comb[31:0];
              r_held_vld <= 1'b1;
              r_acc      <= w_comb[55:32];
            end else begin
              r_held_vld <= 1'b0;
              r_acc      <= w_comb[23:0];
            end
            r_acc_cnt <= w_total[1:0];
            r_partial <= (w_v != r_mask);
            r_cnt     <= w_cnt_next;
          end
        end
        S_FLUSH: begin
          if (r_held_vld) begin
            iface_read_data  <= r_held;
            iface_read_strb  <= 4'hF;
            iface_read_valid <= 1'b1;
            r_held_vld       <= 1'b0;
            iface_read_last  <= (r_acc_cnt == 2'd0);
          end else if (r_acc_cnt != 2'd0) begin
            iface_read_data  <= {8'b0, r_acc};
            iface_read_strb  <= w_part_strb;
            iface_read_valid <= 1'b1;
            iface_read_last  <= 1'b1;
            r_acc            <= '0;
            r_acc_cnt        <= '0;
          end
          // Finished once nothing remains after this cycle's emission.
          if (!(r_held_vld && (r_acc_cnt != 2'd0))) begin
            byte_count <= r_cnt;
            rx_active  <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_DROP: begin
          if (lane_valid == 4'b0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsi_lanes_receiver.sv
// Bench for dsi_lanes_receiver: per-cycle vector table plus a multi-word
// burst sequence with a bounded wait for the last word.
module tb_dsi_lanes_receiver;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [1:0]  reg_lanes_number;
  logic [31:0] lane_data;
  logic [3:0]  lane_valid;
  logic [31:0] iface_read_data;
  logic [3:0]  iface_read_strb;
  logic        iface_read_valid;
  logic        iface_read_last;
  logic        rx_active;
  logic [15:0] byte_count;
  logic        sync_error;
  logic        lane_error;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  dsi_lanes_receiver #(.SYNC_BYTE(8'hB8), .CNT_W(16)) dut (
    .clk_sys(clk_sys), .rst(rst), .reg_lanes_number(reg_lanes_number),
    .lane_data(lane_data), .lane_valid(lane_valid),
    .iface_read_data(iface_read_data), .iface_read_strb(iface_read_strb),
    .iface_read_valid(iface_read_valid), .iface_read_last(iface_read_last),
    .rx_active(rx_active), .byte_count(byte_count),
    .sync_error(sync_error), .lane_error(lane_error)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  lanes;
    logic [31:0] data;
    logic [3:0]  valid;
    logic        e_valid;
    logic [31:0] e_data;
    logic [3:0]  e_strb;
    logic        e_last;
    logic        e_active;
    logic        e_serr;
    logic        e_lerr;
    logic [15:0] e_bc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic [1:0] ln, logic [31:0] d, logic [3:0] v,
                              logic ev, logic [31:0] ed, logic [3:0] es, logic el,
                              logic ea, logic ese, logic ele, logic [15:0] ebc);
    vec_t t;
    t.rst = r; t.lanes = ln; t.data = d; t.valid = v;
    t.e_valid = ev; t.e_data = ed; t.e_strb = es; t.e_last = el;
    t.e_active = ea; t.e_serr = ese; t.e_lerr = ele; t.e_bc = ebc;
    tbl.push_back(t);
  endfunction

  logic [31:0] words[$];
  logic        lasts[$];

  task automatic step_rec();
    @(posedge clk_sys);
    #1;
    if (iface_read_valid) begin
      words.push_back(iface_read_data);
      lasts.push_back(iface_read_last);
    end
  endtask

  initial begin
    bit bad;
    bit got_last;
    logic [31:0] exp_w[3];

    // Reset
    add(1,3,32'h0,4'h0,        0,32'h0,4'h0,0, 0,0,0,16'd0);
    add(1,3,32'h0,4'h0,        0,32'h0,4'h0,0, 0,0,0,16'd0);
    // 4 lanes, 8 bytes
    add(0,3,32'hB8B8B8B8,4'hF, 0,32'h0,4'h0,0, 1,0,0,16'd0);
    add(0,3,32'h04030201,4'hF, 0,32'h0,4'h0,0, 1,0,0,16'd0);
    add(0,3,32'h08070605,4'hF, 1,32'h04030201,4'hF,0, 1,0,0,16'd0);
    add(0,3,32'h0,4'h0,        0,32'h0,4'h0,0, 1,0,0,16'd0);
    add(0,3,32'h0,4'h0,        1,32'h08070605,4'hF,1, 0,0,0,16'd8);
    add(0,3,32'h0,4'h0,        0,32'h0,4'h0,0, 0,0,0,16'd8);
    // 2 lanes, 5 bytes; inactive lanes carry junk valid/data
    add(0,1,32'h0000B8B8,4'h3, 0,32'h0,4'h0,0, 1,0,0,16'd8);
    add(0,1,32'h9999BBAA,4'hF, 0,32'h0,4'h0,0, 1,0,0,16'd8);
    add(0,1,32'h0000DDCC,4'h3, 0,32'h0,4'h0,0, 1,0,0,16'd8);
    add(0,1,32'h777766EE,4'hD, 1,32'hDDCCBBAA,4'hF,0, 1,0,0,16'd8);
    add(0,1,32'h0,4'h0,        0,32'h0,4'h0,0, 1,0,0,16'd8);
    add(0,1,32'h0,4'h0,        1,32'h000000EE,4'h1,1, 0,0,0,16'd5);
    // 1 lane, 3 bytes
    add(0,0,32'h000000B8,4'h1, 0,32'h0,4'h0,0, 1,0,0,16'd5);
    add(0,0,32'h00000011,4'h1, 0,32'h0,4'h0,0, 1,0,0,16'd5);
    add(0,0,32'h00000022,4'h1, 0,32'h0,4'h0,0, 1,0,0,16'd5);
    add(0,0,32'h00000033,4'h1, 0,32'h0,4'h0,0, 1,0,0,16'd5);
    add(0,0,32'h0,4'h0,        0,32'h0,4'h0,0, 1,0,0,16'd5);
    add(0,0,32'h0,4'h0,        1,32'h00332211,4'h7,1, 0,0,0,16'd3);
    // Valid only outside the mask in IDLE: ignored
    add(0,0,32'h0000B8B8,4'h2, 0,32'h0,4'h0,0, 0,0,0,16'd3);
    // Sync error, DROP holds while lanes busy, then a good burst
    add(0,3,32'hB8B9B8B8,4'hF, 0,32'h0,4'h0,0, 0,1,0,16'd3);
    add(0,3,32'hB8B8B8B8,4'hF, 0,32'h0,4'h0,0, 0,0,0,16'd3);
    add(0,3,32'h0,4'h0,        0,32'h0,4'h0,0, 0,0,0,16'd3);
    add(0,3,32'hB8B8B8B8,4'hF, 0,32'h0,4'h0,0, 1,0,0,16'd3);
    add(0,3,32'h44332211,4'hF, 0,32'h0,4'h0,0, 1,0,0,16'd3);
    add(0,3,32'h0,4'h0,        0,32'h0,4'h0,0, 1,0,0,16'd3);
    add(0,3,32'h0,4'h0,        1,32'h44332211,4'hF,1, 0,0,0,16'd4);
    // Lane error: non-prefix pattern
    add(0,3,32'hB8B8B8B8,4'hF, 0,32'h0,4'h0,0, 1,0,0,16'd4);
    add(0,3,32'h01020304,4'hF, 0,32'h0,4'h0,0, 1,0,0,16'd4);
    add(0,3,32'hAAAAAAAA,4'h5, 0,32'h0,4'h0,0, 0,0,1,16'd4);
    add(0,3,32'h0,4'h0,        0,32'h0,4'h0,0, 0,0,0,16'd4);
    add(0,3,32'h0,4'h0,        0,32'h0,4'h0,0, 0,0,0,16'd4);
    // Lane error: data after a partial cycle
    add(0,3,32'hB8B8B8B8,4'hF, 0,32'h0,4'h0,0, 1,0,0,16'd4);
    add(0,3,32'h00002211,4'h3, 0,32'h0,4'h0,0, 1,0,0,16'd4);
    add(0,3,32'h00000033,4'h1, 0,32'h0,4'h0,0, 0,0,1,16'd4);
    add(0,3,32'h0,4'h0,        0,32'h0,4'h0,0, 0,0,0,16'd4);
    // Reset after 6 payload bytes, then a fresh 3-lane burst
    add(0,2,32'h00B8B8B8,4'h7, 0,32'h0,4'h0,0, 1,0,0,16'd4);
    add(0,2,32'h00030201,4'h7, 0,32'h0,4'h0,0, 1,0,0,16'd4);
    add(0,2,32'h00060504,4'h7, 0,32'h0,4'h0,0, 1,0,0,16'd4);
    add(1,2,32'h00090807,4'h7, 0,32'h0,4'h0,0, 0,0,0,16'd0);
    add(0,2,32'h0,4'h0,        0,32'h0,4'h0,0, 0,0,0,16'd0);
    add(0,2,32'h00B8B8B8,4'h7, 0,32'h0,4'h0,0, 1,0,0,16'd0);
    add(0,2,32'h00CCBBAA,4'h7, 0,32'h0,4'h0,0, 1,0,0,16'd0);
    add(0,2,32'h0,4'h0,        0,32'h0,4'h0,0, 1,0,0,16'd0);
    add(0,2,32'h0,4'h0,        1,32'h00CCBBAA,4'h7,1, 0,0,0,16'd3);
    add(0,2,32'h0,4'h0,        0,32'h0,4'h0,0, 0,0,0,16'd3);

    rst = 1'b1; reg_lanes_number = 2'd3; lane_data = '0; lane_valid = '0;

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      reg_lanes_number = tbl[i].lanes;
      lane_data = tbl[i].data;
      lane_valid = tbl[i].valid;
      @(posedge clk_sys);
      #1;
      bad = (iface_read_valid != tbl[i].e_valid) || (rx_active != tbl[i].e_active) ||
            (sync_error != tbl[i].e_serr) || (lane_error != tbl[i].e_lerr) ||
            (byte_count != tbl[i].e_bc) ||
            (tbl[i].e_valid && ((iface_read_data != tbl[i].e_data) ||
                                (iface_read_strb != tbl[i].e_strb) ||
                                (iface_read_last != tbl[i].e_last)));
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL row%0d: got v=%0b d=%h s=%h l=%0b act=%0b se=%0b le=%0b bc=%0d, want v=%0b d=%h s=%h l=%0b act=%0b se=%0b le=%0b bc=%0d",
                 i, iface_read_valid, iface_read_data, iface_read_strb, iface_read_last,
                 rx_active, sync_error, lane_error, byte_count,
                 tbl[i].e_valid, tbl[i].e_data, tbl[i].e_strb, tbl[i].e_last,
                 tbl[i].e_active, tbl[i].e_serr, tbl[i].e_lerr, tbl[i].e_bc);
      end
    end

    // 4 lanes, 12 bytes: three full words, last on the third
    exp_w[0] = 32'h04030201; exp_w[1] = 32'h08070605; exp_w[2] = 32'h0C0B0A09;
    words.delete(); lasts.delete();
    rst = 1'b0; reg_lanes_number = 2'd3;
    lane_data = 32'hB8B8B8B8; lane_valid = 4'hF;
    step_rec();
    for (int b = 0; b < 3; b++) begin
      lane_data = exp_w[b];
      lane_valid = 4'hF;
      step_rec();
    end
    lane_data = '0; lane_valid = 4'h0;
    got_last = 1'b0;
    for (int c = 0; c < 10 && !got_last; c++) begin
      step_rec();
      if (lasts.size() > 0 && lasts[lasts.size()-1]) got_last = 1'b1;
    end
    checks++;
    if (!got_last) begin
      errors++;
      $display("FAIL burst12_timeout: no last word within 10 cycles, words seen %0d", words.size());
    end
    checks++;
    if (words.size() != 3) begin
      errors++;
      $display("FAIL burst12_count: got %0d words, want 3", words.size());
    end
    for (int w = 0; w < 3; w++) begin
      if (w < words.size()) begin
        checks++;
        if (words[w] != exp_w[w] || lasts[w] != (w == 2)) begin
          errors++;
          $display("FAIL burst12_word%0d: got %h last=%0b, want %h last=%0b",
                   w, words[w], lasts[w], exp_w[w], (w == 2));
        end
      end
    end
    @(posedge clk_sys);
    #1;
    checks++;
    if (byte_count != 16'd12 || rx_active != 1'b0) begin
      errors++;
      $display("FAIL burst12_bc: got bc=%0d act=%0b, want bc=12 act=0", byte_count, rx_active);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
